id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised decode stage with an integrated ID/EX output register, valid/ready handshakes on both sides, N-source priority forwarding and a per-register load scoreboard. It sits between the fetch/IF-ID register and the execute stage. It decodes through the existing `controller`, resolves rs1/rs2 operands from the forwarding sources or the register file, and holds back instructions that depend on load data that is not yet available. Unlike the combinational decode stage, it tolerates loads of any memory latency, any number of loads in flight, and stalls from downstream.

## Interface
- XLEN, 32: datapath width, ≥32; the controller's 32-bit immediate is sign-extended to XLEN.
- NUM_FWD, 2: number of forwarding sources; index 0 is the youngest and has the highest priority.
- MAX_LD, 3: maximum number of in-flight loads per destination register; counter width is clog2(MAX_LD+1).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; synchronous, active-low
- in_valid_i / in_ready_o  in/out  1  IF-ID handshake
- instruction_i  in  32  instruction
- pc_i  in  XLEN  instruction PC
- reg_addr1_o, reg_addr2_o  out  5  register-file read addresses (combinational)
- reg_rs1_i, reg_rs2_i  in  XLEN  register-file read data
- fwd_addr_i  in  NUM_FWD*5  forwarding-source destination registers
- fwd_we_i  in  NUM_FWD  source will write its register
- fwd_rdy_i  in  NUM_FWD  source data is valid this cycle
- fwd_data_i  in  NUM_FWD*XLEN  forwarding data
- wb_ld_i  in  1  a load is writing back this cycle
- wb_addr_i  in  5  destination register of that load
- flush_i  in  1  kill the output register and any decode this cycle
- out_valid_o / out_ready_i  out/in  1  ID-EX handshake
- br_sig_o, br_op_o[2:0], lsu_op_o[2:0], alu_op_o[4:0], data_dest_o[1:0], reg_wr_addr_o[4:0], reg_wr_sig_o, mem_wr_sig_o  out  registered controller fields
- imm_o, pc_o, pc_rs1_o, imm_rs2_o, rs2_o  out  XLEN  registered operands
- stall_o  out  1  in_valid_i && hazard (combinational)

## Operation
- **Decode:** combinational, through `controller`. data_dest 2'b01 means load data; "is_load" = reg_wr_sig && data_dest==2'b01 && rd!=0.
- **Operand resolution, per rs:**
  - Address 0 gives 0.
  - Otherwise the lowest index i with fwd_we_i[i] and fwd_addr_i[i]==rs supplies the operand, provided fwd_rdy_i[i]=1. If that source is not ready, this is a hazard.
  - If no source matches, the operand comes from reg_rsN_i.
- **Operand muxes:** pc_rs1 = pc when data_origin[0] is set, else rs1. imm_rs2 = imm when data_origin[1] is set, else rs2.
- **Load scoreboard:** cnt[r] for r=1..31; cnt[0] is hard-wired 0.
  - Increment on an out fire (out_valid_o && out_ready_i) whose output register holds is_load to rd r.
  - Decrement on wb_ld_i with wb_addr_i==r.
  - Increment and decrement in the same cycle on the same register: unchanged.
  - Decrement at 0: stays 0, illegal; the bench asserts it never happens.
- **Hazard** (any of the following):
  - A used rs has cnt[rs]!=0 and is not resolved by a ready forwarding source.
  - The output register is valid, holds is_load, and its rd equals a used rs (load-use).
  - Unready forwarding as described above.
  - The decoded instruction is_load and cnt[rd]==MAX_LD (saturation).
  - rs2 counts as used only when it is read by the ALU or by a store; rs1 only when it is not PC/LUI-sourced.
- **in_ready_o** = !flush_i && !hazard && (!out_valid_o || out_ready_i).
- **Output register:**
  - Loads the decoded fields when in_valid_i && in_ready_o.
  - Else, on an out fire, out_valid_o ← 0.
  - Else holds all fields stable.
- **Flush:** out_valid_o ← 0 and no load that cycle. The scoreboard is not cleared (issued loads still write back). A flushed load was never counted.

## Timing
- Latency is 1 cycle from input fire to out_valid_o.
- Full throughput: one instruction per cycle when there is no hazard and out_ready_i=1.
- Reset (rst_n_i low at a clock edge): out_valid_o=0, all registered outputs 0, all cnt=0. The combinational outputs in_ready_o and stall_o follow their equations after reset. Reset mid-stall discards the pending instruction.
- out_valid_o with its fields must remain stable while out_ready_i=0.
- flush_i together with out_ready_i=1: the flush wins; out_valid_o=0 next cycle. The scoreboard still increments for the fire in that cycle.
- Forwarding data is sampled into the output register only on input fire. Operands never update while the instruction is held.

## Test plan
- **Back-to-back ALU:** `add x3,x1,x2` then `add x4,x3,x3`, with source 0 = {addr 3, we, rdy, data 7} → second instruction's pc_rs1_o=7 and rs2_o=7; no stall; out_valid_o high two consecutive cycles.
- **Load-use:** `lw x5`, then `addi x6,x5,1`. stall_o=1 while `lw` sits in the output register and while cnt[5]=1. When source 1 = {5, we, rdy, 0x55} → pc_rs1_o=0x55.
- **Saturation with MAX_LD=3:** issue three `lw x7` with no writeback → the fourth `lw x7` stalls. A single wb_ld_i with addr 7 → the fourth issues next cycle, cnt[7]=3.
- **Backpressure:** out_ready_i=0 for 4 cycles → in_ready_o=0 and outputs unchanged. Release → issue resumes with no lost or duplicate instruction.
- **Flush:** assert flush_i while `lw x8` is held → out_valid_o=0 next cycle, cnt[8] remains 0, and a following `add x9,x8,x0` does not stall.
- **Reset:** rst_n_i low mid-sequence with cnt[5]=2 → next cycle out_valid_o=0 and all outputs 0. After reset, cnt=0, so `addi x6,x5,1` issues without stall.

Source files
------------

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : controller / id_stage_pipe
// Brief    : RV32I field decoder and a decode stage with ID/EX register,
//            priority forwarding and a per-register in-flight load scoreboard.
// Revision : 1.0
// ============================================================================

module controller (
    input  logic [31:0] i_instr,
    output logic        o_br_sig,
    output logic [2:0]  o_br_op,
    output logic [2:0]  o_lsu_op,
    output logic [4:0]  o_alu_op,
    output logic [1:0]  o_data_dest,
    output logic [1:0]  o_data_origin,
    output logic [4:0]  o_reg_wr_addr,
    output logic        o_reg_wr_sig,
    output logic        o_mem_wr_sig,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr
);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_use_rs1;
    logic        w_use_rs2;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u  = {i_instr[31:12], 12'd0};
    assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Unused source fields are reported as x0 so they never raise a hazard.
    assign o_rs1_addr    = w_use_rs1 ? i_instr[19:15] : 5'd0;
    assign o_rs2_addr    = w_use_rs2 ? i_instr[24:20] : 5'd0;
    assign o_reg_wr_addr = o_reg_wr_sig ? i_instr[11:7] : 5'd0;

    always_comb begin
        o_br_sig      = 1'b0;
        o_br_op       = 3'd0;
        o_lsu_op      = 3'd0;
        o_alu_op      = 5'd0;
        o_data_dest   = 2'b00;
        o_data_origin = 2'b00;
        o_reg_wr_sig  = 1'b0;
        o_mem_wr_sig  = 1'b0;
        o_imm         = 32'd0;
        w_use_rs1     = 1'b0;
        w_use_rs2     = 1'b0;
        case (w_opcode)
            c_OP_LUI: begin
                o_reg_wr_sig  = 1'b1;
                o_data_origin = 2'b10;
                o_imm         = w_imm_u;
            end
            c_OP_AUIPC: begin
                o_reg_wr_sig  = 1'b1;
                o_data_origin = 2'b11;
                o_imm         = w_imm_u;
            end
            c_OP_JAL: begin
                o_br_sig      = 1'b1;
                o_br_op       = 3'b010;
                o_reg_wr_sig  = 1'b1;
                o_data_dest   = 2'b10;
                o_data_origin = 2'b11;
                o_imm         = w_imm_j;
            end
            c_OP_JALR: begin
                o_br_sig      = 1'b1;
                o_br_op       = 3'b011;
                o_reg_wr_sig  = 1'b1;
                o_data_dest   = 2'b10;
                o_data_origin = 2'b10;
                o_imm         = w_imm_i;
                w_use_rs1     = 1'b1;
            end
            c_OP_BRANCH: begin
                o_br_sig      = 1'b1;
                o_br_op       = w_funct3;
                o_alu_op      = {2'b10, w_funct3};
                o_imm         = w_imm_b;
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
            end
            c_OP_LOAD: begin
                o_lsu_op      = w_funct3;
                o_reg_wr_sig  = 1'b1;
                o_data_dest   = 2'b01;
                o_data_origin = 2'b10;
                o_imm         = w_imm_i;
                w_use_rs1     = 1'b1;
            end
            c_OP_STORE: begin
                o_lsu_op      = w_funct3;
                o_mem_wr_sig  = 1'b1;
                o_data_origin = 2'b10;
                o_imm         = w_imm_s;
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
            end
            c_OP_IMM: begin
                o_alu_op      = {1'b0, (w_funct3 == 3'b101) & i_instr[30], w_funct3};
                o_reg_wr_sig  = 1'b1;
                o_data_origin = 2'b10;
                o_imm         = w_imm_i;
                w_use_rs1     = 1'b1;
            end
            c_OP_REG: begin
                o_alu_op      = {1'b0, i_instr[30], w_funct3};
                o_reg_wr_sig  = 1'b1;
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
            end
            default: begin
                o_br_sig = 1'b0;
            end
        endcase
    end

endmodule

module id_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int MAX_LD  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [31:0]             instruction_i,
    input  logic [XLEN-1:0]         pc_i,
    output logic [4:0]              reg_addr1_o,
    output logic [4:0]              reg_addr2_o,
    input  logic [XLEN-1:0]         reg_rs1_i,
    input  logic [XLEN-1:0]         reg_rs2_i,
    input  logic [NUM_FWD*5-1:0]    fwd_addr_i,
    input  logic [NUM_FWD-1:0]      fwd_we_i,
    input  logic [NUM_FWD-1:0]      fwd_rdy_i,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
    input  logic                    wb_ld_i,
    input  logic [4:0]              wb_addr_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    br_sig_o,
    output logic [2:0]              br_op_o,
    output logic [2:0]              lsu_op_o,
    output logic [4:0]              alu_op_o,
    output logic [1:0]              data_dest_o,
    output logic [4:0]              reg_wr_addr_o,
    output logic                    reg_wr_sig_o,
    output logic                    mem_wr_sig_o,
    output logic [XLEN-1:0]         imm_o,
    output logic [XLEN-1:0]         pc_o,
    output logic [XLEN-1:0]         pc_rs1_o,
    output logic [XLEN-1:0]         imm_rs2_o,
    output logic [XLEN-1:0]         rs2_o,
    output logic                    stall_o
);
    localparam int                 c_CNT_W  = $clog2(MAX_LD + 1);
    localparam logic [c_CNT_W:0]   c_MAX_LD = MAX_LD[c_CNT_W:0];

    // Decoded fields
    logic                    w_dec_br_sig;
    logic [2:0]              w_dec_br_op;
    logic [2:0]              w_dec_lsu_op;
    logic [4:0]              w_dec_alu_op;
    logic [1:0]              w_dec_data_dest;
    logic [1:0]              w_dec_data_origin;
    logic [4:0]              w_dec_rd;
    logic                    w_dec_reg_wr_sig;
    logic                    w_dec_mem_wr_sig;
    logic [31:0]             w_dec_imm;
    logic                    w_dec_is_load;
    logic [XLEN-1:0]         w_imm_x;

    // Operand resolution, index 0 = rs1, 1 = rs2
    logic [1:0][4:0]         w_rs_addr;
    logic [1:0][XLEN-1:0]    w_rs_reg;
    logic [1:0][XLEN-1:0]    w_rs_val;
    logic [1:0][XLEN-1:0]    w_fwd_val;
    logic [1:0]              w_fwd_hit;
    logic [1:0]              w_fwd_rdy;
    logic [1:0]              w_rs_haz;

    logic                    w_pend;
    logic                    w_sat;
    logic                    w_hazard;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic [31:0]             w_ld_inc;
    logic [31:0]             w_ld_dec;

    logic [31:0][c_CNT_W-1:0] r_ld_cnt;

    logic                    r_out_valid;
    logic                    r_is_load;
    logic                    r_br_sig;
    logic [2:0]              r_br_op;
    logic [2:0]              r_lsu_op;
    logic [4:0]              r_alu_op;
    logic [1:0]              r_data_dest;
    logic [4:0]              r_rd;
    logic                    r_reg_wr_sig;
    logic                    r_mem_wr_sig;
    logic [XLEN-1:0]         r_imm;
    logic [XLEN-1:0]         r_pc;
    logic [XLEN-1:0]         r_pc_rs1;
    logic [XLEN-1:0]         r_imm_rs2;
    logic [XLEN-1:0]         r_rs2;

    controller u_controller (
        .i_instr       (instruction_i),
        .o_br_sig      (w_dec_br_sig),
        .o_br_op       (w_dec_br_op),
        .o_lsu_op      (w_dec_lsu_op),
        .o_alu_op      (w_dec_alu_op),
        .o_data_dest   (w_dec_data_dest),
        .o_data_origin (w_dec_data_origin),
        .o_reg_wr_addr (w_dec_rd),
        .o_reg_wr_sig  (w_dec_reg_wr_sig),
        .o_mem_wr_sig  (w_dec_mem_wr_sig),
        .o_imm         (w_dec_imm),
        .o_rs1_addr    (w_rs_addr[0]),
        .o_rs2_addr    (w_rs_addr[1])
    );

    assign reg_addr1_o   = w_rs_addr[0];
    assign reg_addr2_o   = w_rs_addr[1];
    assign w_rs_reg[0]   = reg_rs1_i;
    assign w_rs_reg[1]   = reg_rs2_i;
    assign w_dec_is_load = w_dec_reg_wr_sig && (w_dec_data_dest == 2'b01) && (w_dec_rd != 5'd0);

    always_comb begin
        w_imm_x       = {XLEN{w_dec_imm[31]}};
        w_imm_x[31:0] = w_dec_imm;
    end

    always_comb begin
        w_fwd_hit = '0;
        w_fwd_rdy = '0;
        w_fwd_val = '0;
        w_rs_val  = '0;
        w_rs_haz  = '0;
        for (int k = 0; k < 2; k++) begin
            // Walk from the oldest source down so the youngest match wins.
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_we_i[i] && (fwd_addr_i[i*5 +: 5] == w_rs_addr[k])) begin
                    w_fwd_hit[k] = 1'b1;
                    w_fwd_rdy[k] = fwd_rdy_i[i];
                    w_fwd_val[k] = fwd_data_i[i*XLEN +: XLEN];
                end
            end
            if (w_rs_addr[k] == 5'd0) begin
                w_rs_val[k] = '0;
            end else if (w_fwd_hit[k]) begin
                w_rs_val[k] = w_fwd_val[k];
                w_rs_haz[k] = !w_fwd_rdy[k];
            end else begin
                w_rs_val[k] = w_rs_reg[k];
                w_rs_haz[k] = (r_ld_cnt[w_rs_addr[k]] != '0);
            end
            if ((w_rs_addr[k] != 5'd0) && r_out_valid && r_is_load && (r_rd == w_rs_addr[k])) begin
                w_rs_haz[k] = 1'b1;
            end
        end
    end

    // A load still sitting in the output register is about to be counted,
    // so it is included when checking the destination's saturation limit.
    assign w_pend   = r_out_valid && r_is_load && (r_rd == w_dec_rd);
    assign w_sat    = w_dec_is_load &&
                      (({1'b0, r_ld_cnt[w_dec_rd]} + {{c_CNT_W{1'b0}}, w_pend}) >= c_MAX_LD);
    assign w_hazard = (|w_rs_haz) || w_sat;

    assign in_ready_o = !flush_i && !w_hazard && (!r_out_valid || out_ready_i);
    assign stall_o    = in_valid_i && w_hazard;
    assign w_in_fire  = in_valid_i && in_ready_o;
    assign w_out_fire = r_out_valid && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_out_valid  <= 1'b0;
            r_is_load    <= 1'b0;
            r_br_sig     <= 1'b0;
            r_br_op      <= '0;
            r_lsu_op     <= '0;
            r_alu_op     <= '0;
            r_data_dest  <= '0;
            r_rd         <= '0;
            r_reg_wr_sig <= 1'b0;
            r_mem_wr_sig <= 1'b0;
            r_imm        <= '0;
            r_pc         <= '0;
            r_pc_rs1     <= '0;
            r_imm_rs2    <= '0;
            r_rs2        <= '0;
        end else if (w_in_fire) begin
            r_out_valid  <= 1'b1;
            r_is_load    <= w_dec_is_load;
            r_br_sig     <= w_dec_br_sig;
            r_br_op      <= w_dec_br_op;
            r_lsu_op     <= w_dec_lsu_op;
            r_alu_op     <= w_dec_alu_op;
            r_data_dest  <= w_dec_data_dest;
            r_rd         <= w_dec_rd;
            r_reg_wr_sig <= w_dec_reg_wr_sig;
            r_mem_wr_sig <= w_dec_mem_wr_sig;
            r_imm        <= w_imm_x;
            r_pc         <= pc_i;
            r_pc_rs1     <= w_dec_data_origin[0] ? pc_i : w_rs_val[0];
            r_imm_rs2    <= w_dec_data_origin[1] ? w_imm_x : w_rs_val[1];
            r_rs2        <= w_rs_val[1];
        end else if (flush_i || w_out_fire) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign w_ld_inc = (w_out_fire && r_is_load) ? (32'd1 << r_rd) : 32'd0;
    assign w_ld_dec = wb_ld_i ? (32'd1 << wb_addr_i) : 32'd0;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ld_cnt <= '0;
        end else begin
            r_ld_cnt[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                if (w_ld_inc[r] && !w_ld_dec[r]) begin
                    r_ld_cnt[r] <= r_ld_cnt[r] + 1'b1;
                end else if (w_ld_dec[r] && !w_ld_inc[r] && (r_ld_cnt[r] != '0)) begin
                    r_ld_cnt[r] <= r_ld_cnt[r] - 1'b1;
                end
            end
        end
    end

    assign out_valid_o   = r_out_valid;
    assign br_sig_o      = r_br_sig;
    assign br_op_o       = r_br_op;
    assign lsu_op_o      = r_lsu_op;
    assign alu_op_o      = r_alu_op;
    assign data_dest_o   = r_data_dest;
    assign reg_wr_addr_o = r_rd;
    assign reg_wr_sig_o  = r_reg_wr_sig;
    assign mem_wr_sig_o  = r_mem_wr_sig;
    assign imm_o         = r_imm;
    assign pc_o          = r_pc;
    assign pc_rs1_o      = r_pc_rs1;
    assign imm_rs2_o     = r_imm_rs2;
    assign rs2_o         = r_rs2;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_pipe
// Brief    : Directed self-checking bench for id_stage_pipe.
// Revision : 1.0
// ============================================================================
module tb_id_stage_pipe;
    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;
    localparam int MAX_LD  = 3;

    logic                    clk_i = 1'b0;
    logic                    rst_n_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [31:0]             instruction_i;
    logic [XLEN-1:0]         pc_i;
    logic [4:0]              reg_addr1_o;
    logic [4:0]              reg_addr2_o;
    logic [XLEN-1:0]         reg_rs1_i;
    logic [XLEN-1:0]         reg_rs2_i;
    logic [NUM_FWD*5-1:0]    fwd_addr_i;
    logic [NUM_FWD-1:0]      fwd_we_i;
    logic [NUM_FWD-1:0]      fwd_rdy_i;
    logic [NUM_FWD*XLEN-1:0] fwd_data_i;
    logic                    wb_ld_i;
    logic [4:0]              wb_addr_i;
    logic                    flush_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic                    br_sig_o;
    logic [2:0]              br_op_o;
    logic [2:0]              lsu_op_o;
    logic [4:0]              alu_op_o;
    logic [1:0]              data_dest_o;
    logic [4:0]              reg_wr_addr_o;
    logic                    reg_wr_sig_o;
    logic                    mem_wr_sig_o;
    logic [XLEN-1:0]         imm_o;
    logic [XLEN-1:0]         pc_o;
    logic [XLEN-1:0]         pc_rs1_o;
    logic [XLEN-1:0]         imm_rs2_o;
    logic [XLEN-1:0]         rs2_o;
    logic                    stall_o;

    int n_checks = 0;
    int n_errors = 0;

    id_stage_pipe #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .MAX_LD(MAX_LD)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .instruction_i(instruction_i), .pc_i(pc_i),
        .reg_addr1_o(reg_addr1_o), .reg_addr2_o(reg_addr2_o),
        .reg_rs1_i(reg_rs1_i), .reg_rs2_i(reg_rs2_i),
        .fwd_addr_i(fwd_addr_i), .fwd_we_i(fwd_we_i),
        .fwd_rdy_i(fwd_rdy_i), .fwd_data_i(fwd_data_i),
        .wb_ld_i(wb_ld_i), .wb_addr_i(wb_addr_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .br_sig_o(br_sig_o), .br_op_o(br_op_o), .lsu_op_o(lsu_op_o),
        .alu_op_o(alu_op_o), .data_dest_o(data_dest_o),
        .reg_wr_addr_o(reg_wr_addr_o), .reg_wr_sig_o(reg_wr_sig_o),
        .mem_wr_sig_o(mem_wr_sig_o), .imm_o(imm_o), .pc_o(pc_o),
        .pc_rs1_o(pc_rs1_o), .imm_rs2_o(imm_rs2_o), .rs2_o(rs2_o),
        .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Register file model: x[n] reads as 0x100 + n.
    assign reg_rs1_i = 32'h100 + {27'd0, reg_addr1_o};
    assign reg_rs2_i = 32'h100 + {27'd0, reg_addr2_o};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [63:0] cnt(input int r);
        return {62'd0, dut.r_ld_cnt[r]};
    endfunction

    task automatic set_fwd(input int idx, input logic [4:0] addr, input logic we, input logic rdy, input logic [XLEN-1:0] data);
        fwd_addr_i[idx*5 +: 5]       = addr;
        fwd_we_i[idx]                = we;
        fwd_rdy_i[idx]               = rdy;
        fwd_data_i[idx*XLEN +: XLEN] = data;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        in_valid_i    = 1'b1;
        instruction_i = instr;
        pc_i          = pc;
    endtask

    task automatic to_neg();
        @(negedge clk_i);
    endtask

    task automatic to_pos();
        @(posedge clk_i);
        #1;
    endtask

    // Every load writeback must target a register with a load outstanding.
    always @(negedge clk_i) begin
        if (rst_n_i && wb_ld_i) begin
            chk("wb_cnt_nonzero", {63'd0, dut.r_ld_cnt[wb_addr_i] != '0}, 64'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0; in_valid_i = 1'b0; instruction_i = '0; pc_i = '0;
        fwd_addr_i = '0; fwd_we_i = '0; fwd_rdy_i = '0; fwd_data_i = '0;
        wb_ld_i = 1'b0; wb_addr_i = '0; flush_i = 1'b0; out_ready_i = 1'b1;
        to_pos(); to_pos();
        rst_n_i = 1'b1;
        to_neg();
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_pc_rs1", pc_rs1_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        to_pos();

        // Back-to-back ALU with youngest-source forwarding
        set_fwd(0, 5'd3, 1'b1, 1'b1, 32'd7);
        issue(i_add(5'd3, 5'd1, 5'd2), 32'h100);
        to_neg();
        chk("b2b_stall0", stall_o, 0);
        to_pos();
        issue(i_add(5'd4, 5'd3, 5'd3), 32'h104);
        to_neg();
        chk("b2b_v1", out_valid_o, 1);
        chk("b2b_pc1", pc_o, 32'h100);
        chk("b2b_rs1_1", pc_rs1_o, 32'h101);
        chk("b2b_rs2_1", rs2_o, 32'h102);
        chk("b2b_stall1", stall_o, 0);
        to_pos();
        in_valid_i = 1'b0;
        to_neg();
        chk("b2b_v2", out_valid_o, 1);
        chk("b2b_pc2", pc_o, 32'h104);
        chk("b2b_fwd_rs1", pc_rs1_o, 32'd7);
        chk("b2b_fwd_rs2", rs2_o, 32'd7);
        chk("b2b_rd2", reg_wr_addr_o, 4);
        to_pos();
        set_fwd(0, 5'd0, 1'b0, 1'b0, 32'd0);

        // Load-use
        issue(i_lw(5'd5, 5'd1), 32'h200);
        to_pos();
        issue(i_addi(5'd6, 5'd5, 12'd1), 32'h204);
        to_neg();
        chk("lu_dest", data_dest_o, 2'b01);
        chk("lu_stall_reg", stall_o, 1);
        chk("lu_ready", in_ready_o, 0);
        to_pos();
        to_neg();
        chk("lu_cnt1", cnt(5), 1);
        chk("lu_stall_cnt", stall_o, 1);
        set_fwd(0, 5'd5, 1'b1, 1'b0, 32'h11);
        set_fwd(1, 5'd5, 1'b1, 1'b1, 32'h55);
        #1;
        chk("lu_prio_unready", stall_o, 1);
        set_fwd(0, 5'd0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("lu_fwd_stall", stall_o, 0);
        wb_ld_i = 1'b1; wb_addr_i = 5'd5;
        to_pos();
        in_valid_i = 1'b0; wb_ld_i = 1'b0;
        set_fwd(1, 5'd0, 1'b0, 1'b0, 32'd0);
        to_neg();
        chk("lu_fwd_val", pc_rs1_o, 32'h55);
        chk("lu_imm", imm_rs2_o, 1);
        chk("lu_cnt0", cnt(5), 0);
        to_pos();

        // Saturation on x7
        for (int j = 0; j < 3; j++) begin
            issue(i_lw(5'd7, 5'd0), 32'h300 + 32'(4 * j));
            to_neg();
            chk("sat_issue_ready", in_ready_o, 1);
            to_pos();
        end
        issue(i_lw(5'd7, 5'd0), 32'h30c);
        to_neg();
        chk("sat_stall_a", stall_o, 1);
        to_pos();
        to_neg();
        chk("sat_stall_b", stall_o, 1);
        chk("sat_cnt3", cnt(7), 3);
        to_pos();
        wb_ld_i = 1'b1; wb_addr_i = 5'd7;
        to_neg();
        chk("sat_stall_wb", stall_o, 1);
        to_pos();
        wb_ld_i = 1'b0;
        to_neg();
        chk("sat_release", in_ready_o, 1);
        to_pos();
        in_valid_i = 1'b0;
        to_neg();
        chk("sat_pc4", pc_o, 32'h30c);
        to_pos();
        to_neg();
        chk("sat_cnt_after", cnt(7), 3);
        wb_ld_i = 1'b1; wb_addr_i = 5'd7;
        for (int j = 0; j < 3; j++) to_pos();
        wb_ld_i = 1'b0;
        to_neg();
        chk("sat_drain", cnt(7), 0);
        to_pos();

        // Backpressure
        out_ready_i = 1'b0;
        issue(i_add(5'd10, 5'd1, 5'd2), 32'h400);
        to_pos();
        issue(i_add(5'd11, 5'd1, 5'd2), 32'h404);
        for (int j = 0; j < 4; j++) begin
            to_neg();
            chk("bp_ready", in_ready_o, 0);
            chk("bp_pc_hold", pc_o, 32'h400);
            to_pos();
        end
        out_ready_i = 1'b1;
        to_neg();
        chk("bp_release", in_ready_o, 1);
        to_pos();
        in_valid_i = 1'b0;
        to_neg();
        chk("bp_next_pc", pc_o, 32'h404);
        chk("bp_next_rd", reg_wr_addr_o, 11);
        to_pos();
        to_neg();
        chk("bp_drained", out_valid_o, 0);
        to_pos();

        // Flush of a held load
        out_ready_i = 1'b0;
        issue(i_lw(5'd8, 5'd0), 32'h500);
        to_pos();
        in_valid_i = 1'b0; flush_i = 1'b1;
        to_neg();
        chk("fl_ready", in_ready_o, 0);
        to_pos();
        flush_i = 1'b0; out_ready_i = 1'b1;
        issue(i_add(5'd9, 5'd8, 5'd0), 32'h504);
        to_neg();
        chk("fl_valid", out_valid_o, 0);
        chk("fl_cnt8", cnt(8), 0);
        chk("fl_stall", stall_o, 0);
        to_pos();
        in_valid_i = 1'b0;
        to_neg();
        chk("fl_add_rs1", pc_rs1_o, 32'h108);
        chk("fl_add_rs2", rs2_o, 0);
        to_pos();

        // Reset mid-stall with cnt[5]=2
        issue(i_lw(5'd5, 5'd0), 32'h600);
        to_pos();
        issue(i_lw(5'd5, 5'd0), 32'h604);
        to_pos();
        issue(i_addi(5'd6, 5'd5, 12'd1), 32'h608);
        to_pos();
        to_neg();
        chk("rs_cnt2", cnt(5), 2);
        chk("rs_stall", stall_o, 1);
        rst_n_i = 1'b0;
        to_pos();
        rst_n_i = 1'b1;
        to_neg();
        chk("rs_valid", out_valid_o, 0);
        chk("rs_pc", pc_o, 0);
        chk("rs_dest", data_dest_o, 0);
        chk("rs_cnt0", cnt(5), 0);
        chk("rs_no_stall", stall_o, 0);
        to_pos();
        in_valid_i = 1'b0;
        to_neg();
        chk("rs_issue_pc", pc_o, 32'h608);
        chk("rs_issue_rs1", pc_rs1_o, 32'h105);
        to_pos();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
